// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings, handshake
// levels, zero constants and iteration counts.
// Optional macro DIV_RADIX4_EN: when defined, the divider retires two quotient
// bits per iteration edge instead of one.
package div_unit_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Handshake levels
    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    // Common zero words
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [63:0] ZERO_DWORD = 64'h0000_0000_0000_0000;

    // Iteration edges for a 32-bit divide
    localparam int DIV_ITER_R2 = 32;
    localparam int DIV_ITER_R4 = 16;

`ifdef DIV_RADIX4_EN
    localparam int DIV_STEP_BITS = 2;
    localparam int DIV_ITER      = DIV_ITER_R4;
`else
    localparam int DIV_STEP_BITS = 1;
    localparam int DIV_ITER      = DIV_ITER_R2;
`endif

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shifts the next dividend
// bit(s) into the partial remainder and subtracts the divisor magnitude.
// Optional macro DIV_RADIX4_EN: selects the two-bit (radix-4) step.
module div_step
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]        rem_i,
    input  logic [DIV_STEP_BITS-1:0] bits_i,
    input  logic [DATA_W-1:0]        dsr_i,
    output logic [DATA_W-1:0]        rem_o,
    output logic [DIV_STEP_BITS-1:0] q_o
);

`ifdef DIV_RADIX4_EN
    // Trial value and 1x/2x/3x divisor multiples, all 34 bits wide
    logic [DATA_W+1:0] trial;
    logic [DATA_W+1:0] mul1;
    logic [DATA_W+1:0] mul2;
    logic [DATA_W+1:0] mul3;
    // 35-bit differences; the top bit is the borrow
    logic [DATA_W+2:0] diff1;
    logic [DATA_W+2:0] diff2;
    logic [DATA_W+2:0] diff3;

    assign trial = {rem_i, bits_i};
    assign mul1  = {2'b00, dsr_i};
    assign mul2  = {1'b0, dsr_i, 1'b0};
    assign mul3  = mul1 + mul2;
    assign diff1 = {1'b0, trial} - {1'b0, mul1};
    assign diff2 = {1'b0, trial} - {1'b0, mul2};
    assign diff3 = {1'b0, trial} - {1'b0, mul3};

    // Keep the largest multiple that still leaves a non-negative remainder
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
        q_o   = 2'd0;
        rem_o = trial[DATA_W-1:0];
        if (!diff3[DATA_W+2]) begin
            q_o   = 2'd3;
            rem_o = diff3[DATA_W-1:0];
        end else if (!diff2[DATA_W+2]) begin
            q_o   = 2'd2;
            rem_o = diff2[DATA_W-1:0];
        end else if (!diff1[DATA_W+2]) begin
            q_o   = 2'd1;
            rem_o = diff1[DATA_W-1:0];
        end
    end
`else
    // 33-bit trial remainder; the extra difference bit carries the borrow
    logic [DATA_W:0]   trial;
    logic [DATA_W+1:0] diff;

    assign trial = {rem_i, bits_i};
    assign diff  = {1'b0, trial} - {2'b00, dsr_i};
    assign q_o   = ~diff[DATA_W+1];
    assign rem_o = diff[DATA_W+1] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
`endif

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider for the execute stage. Captures the
// operands once, runs a restoring shift-subtract loop, sign-corrects, and
// returns {remainder, quotient} for HI/LO.
// Optional macro DIV_RADIX4_EN: two quotient bits per edge (16 iterations).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst,
    input  logic                div_start_i,
    input  logic                div_annul_i,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   div_opdata1_i,
    input  logic [DATA_W-1:0]   div_opdata2_i,
    output logic                div_ready_o,
    output logic [2*DATA_W-1:0] div_result_o,
    output logic                div_busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER);

    div_state_e state;
    div_state_e state_next;

    logic [CNT_W-1:0]         cnt;
    logic [DATA_W-1:0]        rem_q;      // partial remainder
    logic [DATA_W-1:0]        dvd_q;      // dividend bits out, quotient bits in
    logic [DATA_W-1:0]        dsr_q;      // divisor magnitude
    logic                     signed_q;
    logic                     sign1_q;
    logic                     sign2_q;

    logic [DATA_W-1:0]        mag1;
    logic [DATA_W-1:0]        mag2;
    logic [DATA_W-1:0]        rem_next;
    logic [DIV_STEP_BITS-1:0] q_bits;
    logic [DATA_W-1:0]        quot_fix;
    logic [DATA_W-1:0]        rem_fix;

    // Operand magnitudes: two's-complement absolute value only for DIV
    assign mag1 = (signed_div_i && div_opdata1_i[DATA_W-1]) ? (~div_opdata1_i + 1'b1) : div_opdata1_i;
    assign mag2 = (signed_div_i && div_opdata2_i[DATA_W-1]) ? (~div_opdata2_i + 1'b1) : div_opdata2_i;

    // Sign correction applied on the fix-up edge
    assign quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~dvd_q + 1'b1) : dvd_q;
    assign rem_fix  = (signed_q && sign1_q) ? (~rem_q + 1'b1) : rem_q;

    assign div_busy_o = (state != DIV_FREE);

    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_i  (rem_q),
        .bits_i (dvd_q[DATA_W-1 -: DIV_STEP_BITS]),
        .dsr_i  (dsr_q),
        .rem_o  (rem_next),
        .q_o    (q_bits)
    );

    // State register
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= DIV_FREE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_next;
        end
    end

    // Next-state decode; annul overrides every other condition
    always_comb begin
        state_next = state;
        if (div_annul_i) begin
            state_next = DIV_FREE;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (div_start_i == DIV_START)
                        state_next = (div_opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
                DIV_BY_ZERO: state_next = DIV_END;
                DIV_ON: begin
                    if (cnt == CNT_LAST)
                        state_next = DIV_END;
                end
                DIV_END: begin
                    if (div_ready_o == DIV_READY && div_start_i == DIV_STOP)
                        state_next = DIV_FREE;
                end
                default: state_next = DIV_FREE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, fix-up and result handshake
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            // NOTE: the operand and shift registers are cleared too, so no stale operand survives a reset.
            cnt          <= '0;
            rem_q        <= '0;
            dvd_q        <= '0;
            dsr_q        <= '0;
            signed_q     <= 1'b0;
            sign1_q      <= 1'b0;
            sign2_q      <= 1'b0;
            div_ready_o  <= DIV_NOT_READY;
            div_result_o <= '0;
        end else if (div_annul_i) begin
            cnt          <= '0;
            div_ready_o  <= DIV_NOT_READY;
            div_result_o <= '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    div_ready_o  <= DIV_NOT_READY;
                    div_result_o <= '0;
                    if (div_start_i == DIV_START) begin
                        signed_q <= signed_div_i;
                        sign1_q  <= div_opdata1_i[DATA_W-1];
                        sign2_q  <= div_opdata2_i[DATA_W-1];
                        rem_q    <= '0;
                        dvd_q    <= mag1;
                        dsr_q    <= mag2;
                        cnt      <= '0;
                    end
                end
                DIV_BY_ZERO: begin
                    div_result_o <= '0;
                end
                DIV_ON: begin
                    if (cnt != CNT_LAST) begin
                        rem_q <= rem_next;
                        dvd_q <= {dvd_q[DATA_W-1-DIV_STEP_BITS:0], q_bits};
                        cnt   <= cnt + 1'b1;
                    end else begin
                        div_result_o <= {rem_fix, quot_fix};
                        cnt          <= '0;
                    end
                end
                DIV_END: begin
                    // Ready always rises once, then waits for start to drop
                    if (div_ready_o == DIV_NOT_READY) begin
                        div_ready_o <= DIV_READY;
                    end else if (div_start_i == DIV_STOP) begin
                        div_ready_o  <= DIV_NOT_READY;
                        div_result_o <= '0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider serving the execute stage's DIV/DIVU issue.
- Execute stage is the initiator: holds start plus operands and stalls the pipeline until ready.
- This block is the responder: captures operands, iterates, sign-corrects, and returns {remainder, quotient} on a 64-bit bus destined for HI/LO.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width.

Ports:
- cpu_clk_50M  in  1  system clock, rising edge.
- cpu_rst  in  1  asynchronous active-high reset.
- div_start_i  in  1  request; held high by initiator until div_ready_o is seen.
- div_annul_i  in  1  flush/exception abort; overrides everything.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- div_opdata1_i  in  32  dividend.
- div_opdata2_i  in  32  divisor.
- div_ready_o  out  1  result valid.
- div_result_o  out  64  [63:32] remainder (HI), [31:0] quotient (LO).
- div_busy_o  out  1  high in any state except FREE.

Behaviour:
- Reset (async, cpu_rst=1): state FREE, div_ready_o=0, div_result_o=0, counter=0, operand/shift registers=0.
- States: FREE, BY_ZERO, ON, END. Encodings live in the shared package.
- FREE:
  - If div_start_i=1 and div_annul_i=0, latch signed_div_i, sign bits of both operands, and magnitudes. Magnitudes are the two's-complement absolute values when signed, raw values when unsigned.
  - Divisor=0 -> BY_ZERO; otherwise -> ON with counter=0.
  - While in FREE: ready=0, result=0.
- Operands are latched once. Changes on the inputs during ON/END are ignored.
- ON:
  - Restoring shift-subtract, 1 quotient bit per edge, 32 iteration edges.
  - Partial-remainder subtract is 33 bits wide; borrow bit selects restore or keep.
  - After the last iteration, one fix-up edge:
    - negate quotient if signed and sign1^sign2;
    - negate remainder if signed and sign1.
  - Then -> END.
- BY_ZERO: one edge, result forced to {0,0}, -> END.
- END:
  - div_ready_o=1 and div_result_o holds the final value.
  - If div_start_i=0, next edge -> FREE with ready=0 and result=0.
  - While start stays high, END is held (pipeline-stall case).
- Latency, counted from the edge that samples start in FREE:
  - div_ready_o rises after 34 further edges (32 iterations + fix-up + END entry) in the default build.
  - Divide-by-zero: ready after 2 edges.
- div_annul_i=1 in any state: next edge -> FREE, ready=0, result=0, counter=0. Annul has priority over start on the same edge.
- div_start_i dropping during ON: the operation completes to END, then returns to FREE one edge later. Ready pulses for one cycle.
- Edge cases:
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. Arithmetic wraps; no trap.
  - Divisor magnitude greater than dividend gives quotient 0, remainder = dividend (sign-corrected).
- Back-to-back requests: a new start is accepted only from FREE, so there is a minimum of one idle cycle between ops.

Optional Feature:
- Macro: DIV_RADIX4_EN.
- Defined: ON retires 2 quotient bits per edge.
  - Compare against 1x, 2x and 3x divisor (34-bit multiples, 35-bit subtract results).
  - Pick the largest non-negative result; 16 iteration edges.
  - Ready after 18 edges from the start-sampling edge.
- Undefined: radix-2 datapath as above, ready after 34 edges.
- Results must be bit-identical in both builds. Only latency differs.

Decomposition:
- defines.v additions:
  - state encodings DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END;
  - DIV_START/DIV_STOP, DIV_READY/DIV_NOT_READY;
  - ZERO_WORD and ZERO_DWORD reuse;
  - iteration count constants for the radix-2 and radix-4 cases (32 and 16).
- One natural sub-module: div_step.
  - Combinational single iteration: takes partial remainder and divisor magnitude, returns next remainder and quotient bit(s).
  - Width selected by DIV_RADIX4_EN.
  - FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- DIVU 100/7, start held -> ready after 34 edges (18 with DIV_RADIX4_EN), result {0x00000002, 0x0000000E}. Ready held until start drops, then result 0 next edge.
- DIV -7/2 -> {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- DIV/DIVU with divisor 0 (dividend 0x1234) -> ready after 2 edges, result {0,0}.
- DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- Start DIVU 1000/3, change operands to 5/5 at edge 3 -> result still {1, 333}. Second run: annul at edge 10 -> FREE next edge, ready never rises, busy=0.
- Assert cpu_rst asynchronously mid-ON -> outputs 0 immediately without clock. After release, DIVU 9/3 -> {0, 3}.
